// File: rtl/mem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [0:0] {
      RspOkay  = 1'b0,
      RspError = 1'b1
   } mem_rsp_t;

endpackage

// File: rtl/mem_responder_if.sv
// Load/store request and response handshake bundle between datapath and responder.
interface mem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   modport master (
      output req_valid, req_addr, req_write, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );

endinterface

// File: rtl/mem_responder_data_store.sv
// Synchronous DEPTH x 32 word array with a registered read port.
module data_store #(
   parameter  int unsigned DEPTH = 64,
   localparam int unsigned IW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          we,
   input  logic          re,
   input  logic          clr,
   input  logic [IW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];

   // Array contents deliberately have no reset.
   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[idx] <= wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || clr) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem_q[idx];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: accepts one request, waits LATENCY cycles,
// commits the access and holds the response until the initiator takes it.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input logic            clock,
   input logic            reset,
   mem_responder_if.slave bus
);

   localparam int unsigned IW   = $clog2(DEPTH);
   localparam int unsigned CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned OFS  = $clog2(WORD_BYTES);
   localparam int unsigned IDXW = 32 - OFS;

   mem_state_t  state_q;
   logic [CW-1:0] cnt_q;
   logic [31:0] addr_q;
   logic        write_q;
   logic [31:0] wdata_q;
   logic        req_ready_q;
   logic        rsp_valid_q;
   mem_rsp_t    rsp_code_q;

   logic [IDXW-1:0] word_idx;
   logic            addr_err;
   logic            commit;
   logic [31:0]     rdata;

   // Offset from the base wraps in 32 bits, so addresses below BASE_ADDR land out of range.
   assign word_idx = IDXW'((addr_q - BASE_ADDR) >> OFS);
   assign addr_err = (addr_q[OFS-1:0] != '0) || ({{OFS{1'b0}}, word_idx} >= DEPTH);
   assign commit   = (state_q == WAIT) && (cnt_q == '0) && !reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_code_q  <= RspOkay;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  addr_q      <= bus.req_addr;
                  write_q     <= bus.req_write;
                  wdata_q     <= bus.req_wdata;
                  cnt_q       <= CW'(LATENCY - 1);
                  req_ready_q <= 1'b0;
                  state_q     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  rsp_valid_q <= 1'b1;
                  rsp_code_q  <= addr_err ? RspError : RspOkay;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_code_q  <= RspOkay;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   data_store #(
      .DEPTH (DEPTH)
   ) u_store (
      .clock (clock),
      .reset (reset),
      .we    (commit && write_q && !addr_err),
      .re    (commit && !write_q && !addr_err),
      .clr   (commit && (write_q || addr_err)),
      .idx   (word_idx[IW-1:0]),
      .wdata (wdata_q),
      .rdata (rdata)
   );

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata;
   assign bus.rsp_error = (rsp_code_q == RspError);

endmodule
